// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the CPU memory stage and a
// word-only data memory. Byte/halfword/word loads use lane extraction with
// sign or zero extension; sub-word stores use a two-cycle read-modify-write.
// Misaligned or out-of-range requests complete with err=1 and no memory access.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req, we, size,       CPU request (sampled only in IDLE); size 00 byte,
//   sign_ext, addr,      01 half, 10 word, 11 error; wdata right-justified
//   wdata
//   ready                1 while in IDLE
//   done, err, rdata     registered completion pulse, error flag, load result
//   mem_rd, mem_wr,      data-memory strobes, word-aligned address, write data
//   mem_addr, mem_wdata
//   mem_rdata            data-memory read data (combinational)
module mem_access_unit #(
  parameter int unsigned RAM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic [WORD_W-1:0]   merge_q, merge_d;
  // Latched request fields; only what the MERGE write needs is kept
  // (sign_ext and the word size only matter in the accept cycle).
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic                half_q, half_d;
  logic [HALF_W-1:0]   wdata_q, wdata_d;

  logic                req_err_c;
  logic [4:0]          rd_sh_c;
  logic [WORD_W-1:0]   rd_shift_c;
  logic [WORD_W-1:0]   load_val_c;
  logic [4:0]          wr_sh_c;
  logic [WORD_W-1:0]   lane_mask_c;
  logic [WORD_W-1:0]   merged_c;

  // Request classification: bad size, misalignment or out-of-range address.
  always_comb begin
    req_err_c = (size == 2'b11)
             || ((size == 2'b01) && addr[0])
             || ((size == 2'b10) && (addr[1:0] != 2'b00))
             || (addr >= 32'(RAM_BYTES));
  end

  // Load lane extraction from the live read data.
  always_comb begin
    rd_sh_c    = {addr[1:0], 3'b000};
    rd_shift_c = mem_rdata >> rd_sh_c;
    case (size)
      2'b00:   load_val_c = {{24{sign_ext & rd_shift_c[7]}}, rd_shift_c[7:0]};
      2'b01:   load_val_c = {{16{sign_ext & rd_shift_c[15]}}, rd_shift_c[15:0]};
      default: load_val_c = mem_rdata;
    endcase
  end

  // Replace the target lane of the previously read word with the store data.
  always_comb begin
    wr_sh_c     = {addr_q[1:0], 3'b000};
    lane_mask_c = half_q ? (32'h0000_FFFF << wr_sh_c) : (32'h0000_00FF << wr_sh_c);
    merged_c    = (merge_q & ~lane_mask_c) | ((32'(wdata_q) << wr_sh_c) & lane_mask_c);
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
      addr_q  <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and memory strobe logic.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    merge_d   = merge_q;
    addr_d    = addr_q;
    half_d    = half_q;
    wdata_d   = wdata_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {addr[31:2], 2'b00};
    mem_wdata = wdata;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          half_d  = size[0];
          wdata_d = wdata[HALF_W-1:0];
          state_d = RESP;
          done_d  = 1'b1;
          if (req_err_c) begin
            err_d = 1'b1;
          end else if (!we) begin
            mem_rd  = 1'b1;
            rdata_d = load_val_c;
            err_d   = 1'b0;
          end else if (size == 2'b10) begin
            mem_wr = 1'b1;
            err_d  = 1'b0;
          end else begin
            // Sub-word store: read the word now, write the merged word next cycle.
            mem_rd  = 1'b1;
            merge_d = mem_rdata;
            state_d = MERGE;
            done_d  = 1'b0;
          end
        end
      end
      MERGE: begin
        mem_wr    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = merged_c;
        err_d     = 1'b0;
        done_d    = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: each accepted request pushes its
// expected result; a negedge monitor pops and compares on every done pulse.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_rd;
    int          n_wr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_rdata = 32'h0;

  logic [31:0] mem [0:63];

  mem_access_unit #(.RAM_BYTES(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory model: combinational read, write on rising edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: counts cycles and strobes from the accept cycle through done.
  int cyc = 0, n_rd = 0, n_wr = 0;
  always @(negedge clk) begin
    if (reset || (ready && !req)) begin
      cyc = 0; n_rd = 0; n_wr = 0;
    end else begin
      cyc++;
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
      if (done) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata", rdata, e.rdata);
          check("err", 32'(err), 32'(e.err));
          check("latency", 32'(cyc), 32'(e.lat));
          check("n_mem_rd", 32'(n_rd), 32'(e.n_rd));
          check("n_mem_wr", 32'(n_wr), 32'(e.n_wr));
          check("ready_in_resp", 32'(ready), 32'd0);
        end
        cyc = 0; n_rd = 0; n_wr = 0;
      end
    end
  end

  // Expected outcome of one request, from the request alone.
  function automatic exp_t model(input logic w, input logic [1:0] sz,
                                 input logic e_err, input logic [31:0] ld_val);
    exp_t e;
    e.err   = e_err;
    e.rdata = (!e_err && !w) ? ld_val : last_rdata;
    if (e_err)            begin e.lat = 2; e.n_rd = 0; e.n_wr = 0; end
    else if (!w)          begin e.lat = 2; e.n_rd = 1; e.n_wr = 0; end
    else if (sz == 2'b10) begin e.lat = 2; e.n_rd = 0; e.n_wr = 1; end
    else                  begin e.lat = 3; e.n_rd = 1; e.n_wr = 1; end
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
  endtask

  // Drive one request; push its expected result at the accept edge if asked.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic push, input logic e_err, input logic [31:0] ld_val);
    exp_t e;
    wait_ready();
    set_req(w, sz, sx, a, wd);
    e = model(w, sz, e_err, ld_val);
    @(posedge clk);
    if (push) begin
      exp_q.push_back(e);
      last_rdata = e.rdata;
    end
    #1;
    req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    time t_prev;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;

    // Word store then word load.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    drain();

    // Byte store: read-modify-write.
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 1'b1, 1'b0, 32'h0);
    drain();
    check("sb_merge_word", mem[4], 32'hDEAD_AAEF);

    // Lane-extracting loads over 0xDEADBEEF.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFDE);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 32'h0000_00DE);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFF_DEAD);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000_DEAD);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFEF);
    // Half store into upper half.
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 1'b1, 1'b0, 32'h0);
    drain();
    check("sh_merge_word", mem[4], 32'h1234_BEEF);

    // Error cases: no memory access, rdata unchanged.
    issue(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    drain();
    check("err_sw_mem", mem[4], 32'h1234_BEEF);

    // Reset during the MERGE cycle of a half store.
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h1122_3344, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    drain();
    issue(1'b1, 2'b01, 1'b0, 32'h14, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_merge_wr", 32'(mem_wr), 32'd0);
    check("rst_merge_ready", 32'(ready), 32'd1);
    check("rst_merge_done", 32'(done), 32'd0);
    check("rst_merge_err", 32'(err), 32'd0);
    check("rst_merge_rdata", rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    last_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_merge_mem", mem[5], 32'h1122_3344);

    // Held req: accepts every two cycles.
    wait_ready();
    set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      wait_ready();
      e = model(1'b0, 2'b10, 1'b0, 32'h1234_BEEF);
      @(posedge clk);
      exp_q.push_back(e);
      last_rdata = e.rdata;
      if (k > 0) check("accept_spacing", 32'($time - t_prev), 32'd20);
      t_prev = $time;
      #1;
    end
    req = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the CPU memory stage and the word-only data memory. It turns byte, halfword and word loads and stores into word-aligned data-memory accesses. Sub-word stores use a two-cycle read-modify-write; loads get byte-lane extraction with sign or zero extension. It also flags misaligned and out-of-range requests without touching memory.

## Interface
Parameters:
- RAM_BYTES, 256: size of the data-memory byte address space. Requests with addr >= RAM_BYTES are errors.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  request from CPU; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word; 11 is an error
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends
- addr  in  32  byte address
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- ready  out  1  1 while in IDLE
- done  out  1  one-cycle registered completion pulse
- err  out  1  registered; valid with done; holds until next done
- rdata  out  32  registered load result; updates only on a successful load
- mem_rd  out  1  data-memory read enable
- mem_wr  out  1  data-memory write enable
- mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}
- mem_wdata  out  32  data-memory write data
- mem_rdata  in  32  data-memory read data; combinational, same cycle as mem_rd

## Operation
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k].
- FSM states: IDLE, MERGE, RESP. Reset drives state to IDLE and clears done, err, rdata and the merge register to 0.
- IDLE, req=0: no memory strobes.
- IDLE, req=1: the request is accepted at the rising edge. addr, size, wdata and sign_ext are latched, so the CPU need not hold them. The first matching case applies:
  - Error: size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr >= RAM_BYTES. No mem_rd or mem_wr is issued. err is set to 1; next state RESP.
  - Load: mem_rd=1. The selected lane of mem_rdata is extended per sign_ext and captured into rdata. err=0; next state RESP.
  - Word store: mem_wr=1, mem_wdata=wdata. err=0; next state RESP.
  - Byte or half store: mem_rd=1. mem_rdata is captured into the merge register; next state MERGE.
- MERGE: mem_wr=1 at the latched word address. mem_wdata is the merge register with the target lane replaced by the latched wdata. err=0; next state RESP.
- RESP: done=1 for exactly this cycle; req is ignored. Next state IDLE.
- In IDLE, mem_rd, mem_wr, mem_addr and mem_wdata are combinational from req and the request inputs. In MERGE they are driven from latched values.
- When no strobe is active, mem_addr and mem_wdata are don't-care and mem_rd=mem_wr=0.

## Timing
- Word load, word store, and error: accepted at edge N, done=1 in cycle N+1, ready again in cycle N+2.
- Sub-word store: read at edge N, write committed at edge N+1, done=1 in cycle N+2.
- A sub-word store produces exactly one mem_wr cycle; a load produces no mem_wr cycle.
- If req is held high, the next request is accepted in the first IDLE cycle after RESP. There are no back-to-back accepts.
- Reset mid-operation (any state) returns to IDLE immediately. A pending MERGE write is never issued, and done and err go to 0.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10. Required: rdata=0xDEADBEEF, and done exactly 1 cycle after each accept.
- sb 0x000000AA to 0x11 over 0xDEADBEEF. Required: mem_rd in the accept cycle, a single mem_wr in the next cycle with mem_wdata=0xDEADAAEF, and done in the cycle after that.
- Loads over word 0xDEADBEEF at 0x10. Required: lb 0x13 gives 0xFFFFFFDE; lbu 0x13 gives 0x000000DE; lh 0x12 gives 0xFFFFDEAD; lhu 0x12 gives 0x0000DEAD; lb 0x10 gives 0xFFFFFFEF.
- Misaligned lh at 0x11, word store at 0x12, and word load at 0x100 (RAM_BYTES=256). Each required: err=1, done=1, no mem_rd or mem_wr, rdata unchanged.
- Assert reset during the MERGE cycle of sh 0x1234 to 0x14. Required: no mem_wr, memory word unchanged, and state, done and err reset immediately.
- Hold req high with word loads. Required: accepts every 2 cycles only, and ready=0 in the RESP cycle.
